// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light controller front end.
// Provides the demand code enum and the helper that maps debounced near/far levels to a code.
package traffic_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2,
    FAULT = 2'd3
  } demand_t;

  localparam int NUM_APPROACHES          = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_FAULT_CYCLES    = 16;

  // A far-only pattern is physically implausible; it reads as a fault only when detection is built in.
  function automatic demand_t classify_demand(input logic d1, input logic d5, input logic fault_en);
    demand_t code;
    case ({d1, d5})
      2'b00:   code = NONE;
      2'b10:   code = SHORT;
      2'b11:   code = LONG;
      default: code = fault_en ? FAULT : LONG;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle of sensor_conditioner: raw loop inputs, debounced levels, demand codes and flags.
// The master modport drives the raw sensors; the slave modport is the conditioner itself.
interface sensor_conditioner_if;

  logic       i_sensor_1_1, i_sensor_2_1, i_sensor_3_1, i_sensor_4_1;
  logic       i_sensor_1_5, i_sensor_2_5, i_sensor_3_5, i_sensor_4_5;
  logic       o_sensor_1_1, o_sensor_2_1, o_sensor_3_1, o_sensor_4_1;
  logic       o_sensor_1_5, o_sensor_2_5, o_sensor_3_5, o_sensor_4_5;
  logic [1:0] o_demand_1, o_demand_2, o_demand_3, o_demand_4;
  logic       o_demand_change;
  logic [3:0] o_fault;

  modport master (
    output i_sensor_1_1, i_sensor_2_1, i_sensor_3_1, i_sensor_4_1,
    output i_sensor_1_5, i_sensor_2_5, i_sensor_3_5, i_sensor_4_5,
    input  o_sensor_1_1, o_sensor_2_1, o_sensor_3_1, o_sensor_4_1,
    input  o_sensor_1_5, o_sensor_2_5, o_sensor_3_5, o_sensor_4_5,
    input  o_demand_1, o_demand_2, o_demand_3, o_demand_4,
    input  o_demand_change,
    input  o_fault
  );

  modport slave (
    input  i_sensor_1_1, i_sensor_2_1, i_sensor_3_1, i_sensor_4_1,
    input  i_sensor_1_5, i_sensor_2_5, i_sensor_3_5, i_sensor_4_5,
    output o_sensor_1_1, o_sensor_2_1, o_sensor_3_1, o_sensor_4_1,
    output o_sensor_1_5, o_sensor_2_5, o_sensor_3_5, o_sensor_4_5,
    output o_demand_1, o_demand_2, o_demand_3, o_demand_4,
    output o_demand_change,
    output o_fault
  );

endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchroniser followed by a counting debounce filter.
// The debounced level follows the synchronised input only after DEBOUNCE_CYCLES consecutive mismatches.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any agreement between input and output discards a partial count, so glitches never accumulate.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST_CNT) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the eight raw loop sensors and publishes registered per-approach demand codes.
// Define SENSOR_FAULT_DETECT_EN to flag far-only patterns as FAULT with sticky per-approach fault bits.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef SENSOR_FAULT_DETECT_EN
  ,
  parameter int FAULT_CYCLES = DEFAULT_FAULT_CYCLES
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  sensor_conditioner_if.slave sc
);

`ifdef SENSOR_FAULT_DETECT_EN
  localparam logic FAULT_EN = 1'b1;
`else
  localparam logic FAULT_EN = 1'b0;
`endif

  logic [NUM_APPROACHES-1:0] raw_near, raw_far;
  logic [NUM_APPROACHES-1:0] level_near, level_far;

  assign raw_near = {sc.i_sensor_4_1, sc.i_sensor_3_1, sc.i_sensor_2_1, sc.i_sensor_1_1};
  assign raw_far  = {sc.i_sensor_4_5, sc.i_sensor_3_5, sc.i_sensor_2_5, sc.i_sensor_1_5};

  for (genvar a = 0; a < NUM_APPROACHES; a++) begin : g_chan
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_near (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_near[a]),
      .level (level_near[a])
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_far (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_far[a]),
      .level (level_far[a])
    );
  end

  assign sc.o_sensor_1_1 = level_near[0];
  assign sc.o_sensor_2_1 = level_near[1];
  assign sc.o_sensor_3_1 = level_near[2];
  assign sc.o_sensor_4_1 = level_near[3];
  assign sc.o_sensor_1_5 = level_far[0];
  assign sc.o_sensor_2_5 = level_far[1];
  assign sc.o_sensor_3_5 = level_far[2];
  assign sc.o_sensor_4_5 = level_far[3];

  demand_t demand_q [NUM_APPROACHES];
  demand_t demand_d [NUM_APPROACHES];
  logic    change_q, change_d;

  // One change pulse covers every approach that moved on the same edge.
  always_comb begin
    change_d = 1'b0;
    for (int a = 0; a < NUM_APPROACHES; a++) begin
      demand_d[a] = classify_demand(level_near[a], level_far[a], FAULT_EN);
      if (demand_d[a] != demand_q[a]) begin
        change_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NUM_APPROACHES; a++) begin
        demand_q[a] <= NONE;
      end
      change_q <= 1'b0;
    end else begin
      for (int a = 0; a < NUM_APPROACHES; a++) begin
        demand_q[a] <= demand_d[a];
      end
      change_q <= change_d;
    end
  end

  assign sc.o_demand_1      = demand_q[0];
  assign sc.o_demand_2      = demand_q[1];
  assign sc.o_demand_3      = demand_q[2];
  assign sc.o_demand_4      = demand_q[3];
  assign sc.o_demand_change = change_q;

`ifdef SENSOR_FAULT_DETECT_EN
  localparam int FW = $clog2(FAULT_CYCLES + 1);
  localparam logic [FW-1:0] FAULT_LIMIT = FW'(FAULT_CYCLES);

  logic [FW-1:0]             fault_cnt_q [NUM_APPROACHES];
  logic [FW-1:0]             fault_cnt_d [NUM_APPROACHES];
  logic [NUM_APPROACHES-1:0] fault_q, fault_d;

  // The persistence counter saturates and restarts from zero whenever the far-only pattern breaks.
  always_comb begin
    fault_d = fault_q;
    for (int a = 0; a < NUM_APPROACHES; a++) begin
      fault_cnt_d[a] = '0;
      if (!level_near[a] && level_far[a]) begin
        fault_cnt_d[a] = (fault_cnt_q[a] == FAULT_LIMIT) ? fault_cnt_q[a] : fault_cnt_q[a] + FW'(1);
      end
      if (fault_cnt_d[a] == FAULT_LIMIT) begin
        fault_d[a] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NUM_APPROACHES; a++) begin
        fault_cnt_q[a] <= '0;
      end
      fault_q <= '0;
    end else begin
      for (int a = 0; a < NUM_APPROACHES; a++) begin
        fault_cnt_q[a] <= fault_cnt_d[a];
      end
      fault_q <= fault_d;
    end
  end

  assign sc.o_fault = fault_q;
`else
  assign sc.o_fault = '0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with DEBOUNCE_CYCLES=4 (and FAULT_CYCLES=16 when SENSOR_FAULT_DETECT_EN is defined).
module tb_sensor_conditioner;
  import traffic_pkg::*;

`ifdef SENSOR_FAULT_DETECT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  // Output selectors: 0..3 near levels, 4..7 far levels, 8..11 demand codes, 12 change, 13 fault.
  localparam int SEL_CHG   = 12;
  localparam int SEL_FAULT = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  logic [3:0] nearVal;
  logic [3:0] farVal;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      tag;
  } sb_entry_t;

  sb_entry_t sb[$];

  sensor_conditioner_if sc ();

  sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sc    (sc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      0:         return {7'd0, sc.o_sensor_1_1};
      1:         return {7'd0, sc.o_sensor_2_1};
      2:         return {7'd0, sc.o_sensor_3_1};
      3:         return {7'd0, sc.o_sensor_4_1};
      4:         return {7'd0, sc.o_sensor_1_5};
      5:         return {7'd0, sc.o_sensor_2_5};
      6:         return {7'd0, sc.o_sensor_3_5};
      7:         return {7'd0, sc.o_sensor_4_5};
      8:         return {6'd0, sc.o_demand_1};
      9:         return {6'd0, sc.o_demand_2};
      10:        return {6'd0, sc.o_demand_3};
      11:        return {6'd0, sc.o_demand_4};
      SEL_CHG:   return {7'd0, sc.o_demand_change};
      SEL_FAULT: return {4'd0, sc.o_fault};
      default:   return 8'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] near, input logic [3:0] far);
    nearVal = near;
    farVal  = far;
    sc.i_sensor_1_1 = near[0];
    sc.i_sensor_2_1 = near[1];
    sc.i_sensor_3_1 = near[2];
    sc.i_sensor_4_1 = near[3];
    sc.i_sensor_1_5 = far[0];
    sc.i_sensor_2_5 = far[1];
    sc.i_sensor_3_5 = far[2];
    sc.i_sensor_4_5 = far[3];
  endtask

  task automatic expectAt(input int off, input int sel, input logic [7:0] exp, input string tag);
    sb_entry_t e;
    e.due = cyc + off;
    e.sel = sel;
    e.exp = exp;
    e.tag = $sformatf("%s_off%0d", tag, off);
    sb.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    for (int s = 0; s <= SEL_FAULT; s++) begin
      checkOutput($sformatf("%s_sel%0d", tag, s), observe(s), 8'd0);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checkOutput("drain_timeout", 8'(sb.size()), 8'd0);
      sb.delete();
    end
  endtask

  // All eight sensors rising together from a cleared state: levels at +6, LONG and one pulse at +7.
  task automatic expectAllRise();
    for (int off = 1; off <= 9; off++) begin
      for (int s = 0; s < 8; s++) expectAt(off, s, 8'(off >= 6), $sformatf("lvl%0d", s));
      for (int a = 0; a < 4; a++) expectAt(off, 8 + a, (off >= 7) ? 8'(LONG) : 8'(NONE), $sformatf("dem%0d", a + 1));
      expectAt(off, SEL_CHG, 8'(off == 7), "chg");
      expectAt(off, SEL_FAULT, 8'd0, "fault");
    end
  endtask

  always @(negedge clk) begin
    sb_entry_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.sel), e.exp);
    end
  end

  initial begin
    applyStimulus(4'hF, 4'hF);
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkAllZero("rst_hold");
    end

    $display("[TB] release reset with all sensors high");
    rst_n = 1'b1;
    expectAllRise();
    waitDrain(30);

    $display("[TB] approach 1 far sensor drops");
    @(negedge clk);
    applyStimulus(4'hF, 4'b1110);
    for (int off = 1; off <= 9; off++) begin
      expectAt(off, 4, 8'(off < 6), "far1");
      expectAt(off, 8, (off >= 7) ? 8'(SHORT) : 8'(LONG), "dem1");
      for (int a = 1; a < 4; a++) expectAt(off, 8 + a, 8'(LONG), $sformatf("dem%0d", a + 1));
      expectAt(off, SEL_CHG, 8'(off == 7), "chg");
    end
    waitDrain(30);

    $display("[TB] approach 2 goes idle, then a 3-cycle glitch");
    @(negedge clk);
    applyStimulus(4'b1101, 4'b1100);
    for (int off = 1; off <= 9; off++) begin
      expectAt(off, 9, (off >= 7) ? 8'(NONE) : 8'(LONG), "dem2_idle");
      expectAt(off, SEL_CHG, 8'(off == 7), "chg_idle");
    end
    waitDrain(30);
    @(negedge clk);
    applyStimulus(4'b1111, 4'b1100);
    for (int off = 1; off <= 12; off++) begin
      expectAt(off, 1, 8'd0, "glitch_near2");
      expectAt(off, 9, 8'(NONE), "glitch_dem2");
      expectAt(off, SEL_CHG, 8'd0, "glitch_chg");
    end
    repeat (3) @(negedge clk);
    applyStimulus(4'b1101, 4'b1100);
    waitDrain(30);

    $display("[TB] approach 3 far-only pattern for 40 cycles");
    @(negedge clk);
    applyStimulus(4'b1001, 4'b1100);
    for (int off = 1; off <= 40; off++) begin
      expectAt(off, 2, 8'(off < 6), "near3");
      expectAt(off, 10, (FEN && off >= 7) ? 8'(FAULT) : 8'(LONG), "dem3");
      expectAt(off, SEL_CHG, 8'(FEN && off == 7), "chg");
      expectAt(off, SEL_FAULT, (FEN && off >= 22) ? 8'h04 : 8'h00, "fault");
    end
    repeat (40) @(negedge clk);
    applyStimulus(4'b1101, 4'b1100);
    for (int off = 1; off <= 10; off++) begin
      expectAt(off, 10, (off >= 7 || !FEN) ? 8'(LONG) : 8'(FAULT), "dem3_end");
      expectAt(off, SEL_CHG, 8'(FEN && off == 7), "chg_end");
      expectAt(off, SEL_FAULT, FEN ? 8'h04 : 8'h00, "fault_end");
    end
    waitDrain(30);

    $display("[TB] reset asserted mid-count");
    @(negedge clk);
    applyStimulus(4'hF, 4'hF);
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_near2", observe(1), 8'd0);
    checkOutput("pre_rst_far2", observe(5), 8'd0);
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    repeat (2) begin
      @(negedge clk);
      checkAllZero("rst_mid");
    end
    rst_n = 1'b1;
    expectAllRise();
    waitDrain(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
